pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
- Pipeline register chain F/D, D/E, E/M and M/W for the 5-stage MIPS core.
- Produces the per-stage instruction words (instrD, instrE, instrM, instrW) consumed by the decode-stage branch forwarding unit and the other forward/stall units.
- Also carries PC+8 and result values that those units' mux selects pick from.
- Applies hazard-unit stalls by freezing F/D and injecting a bubble into D/E.
- Keeps a saturating bubble counter for performance checks.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction injected as bubble and used as reset value (sll $0,$0,0).
- CNT_W, 32, width of the bubble counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  from the stall unit: hold F/D, bubble D/E.
- instr_F  input  32  fetched instruction.
- pc_F  input  32  PC of the fetched instruction.
- alu_out_E  input  32  E-stage ALU result.
- rt_data_E  input  32  forwarded rt value in E (store data).
- dm_rdata_M  input  32  data-memory read data in M.
- instrD / instrE / instrM / instrW  output  32 each  instruction held in the D/E/M/W stage registers.
- pc8_D / pc8_E / pc8_M / pc8_W  output  32 each  PC+8 of that stage's instruction (jal link value).
- alu_M  output  32  registered alu_out_E.
- st_data_M  output  32  registered rt_data_E.
- alu_W  output  32  registered alu_M.
- mem_W  output  32  registered dm_rdata_M.
- bubble_cnt  output  CNT_W  number of bubbles injected since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, named rst_n.
- On rst_n=0, immediately:
  - all instr* = NOP_WORD;
  - all pc8_* = 0;
  - alu_M, st_data_M, alu_W, mem_W = 0;
  - bubble_cnt = 0.
- Reset deassertion takes effect at the next rising clk edge. Reset mid-stall discards all state; the stall is not remembered.
- Normal cycle (stall=0), every stage advances on each rising edge:
  - instrD <= instr_F; pc8_D <= pc_F + 8 (32-bit wrap, no overflow flag).
  - instrE <= instrD; pc8_E <= pc8_D.
  - instrM <= instrE; pc8_M <= pc8_E; alu_M <= alu_out_E; st_data_M <= rt_data_E.
  - instrW <= instrM; pc8_W <= pc8_M; alu_W <= alu_M; mem_W <= dm_rdata_M.
- Stall cycle (stall=1):
  - instrD and pc8_D hold.
  - instrE <= NOP_WORD; pc8_E <= 0.
  - M and W stages advance normally, so the producer drains and forwarding resolves on the next cycle.
  - bubble_cnt <= bubble_cnt + 1, saturating at all-ones (stays at 2^CNT_W-1).
- Consecutive stalls: D holds for the whole run. One NOP enters E per stalled cycle, and each one is counted.
- Latency: one cycle per stage. An instruction presented at instr_F with stall=0 appears on instrW after 4 rising edges.
- No branch flush: delay slot semantics, so the instruction after a branch always proceeds.
- A bubble is indistinguishable from a real sll $0,$0,0. Downstream units treat both as non-writing, so no valid bit is needed.
- All outputs are registered directly; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - NOP_WORD constant;
  - PC8_OFFSET = 8;
  - stage index enum (STG_D=0, STG_E=1, STG_M=2, STG_W=3) shared with the forward and stall units.
- One sub-module, pipe_reg, instantiated per stage/field:
  - parameterised width, async active-low reset to a parameter value;
  - inputs en (load) and clr (load reset value synchronously), with clr taking priority over en.
- Stage wiring:
  - F/D uses en = ~stall, clr = 0.
  - D/E uses en = 1, clr = stall.
  - E/M and M/W use en = 1, clr = 0.

Test Plan:
- Reset hold:
  - drive rst_n=0 mid-cycle with non-zero state present → all outputs 0 / NOP_WORD immediately, without waiting for an edge;
  - release → first edge loads instr_F=32'h2008_0005, pc_F=32'h3000 into instrD, with pc8_D=32'h3008.
- Straight flow:
  - feed addi, ori, add, sw on consecutive cycles, stall=0 → addi appears on instrW at edge 4;
  - each stage's pc8 = its own pc+8;
  - alu_W equals alu_out_E from two cycles earlier.
- Single stall (lw $1 followed by beq $1,$2):
  - assert stall for one cycle → instrD holds beq for 2 cycles;
  - instrE = 0 for one cycle;
  - lw reaches instrW one cycle after the stall;
  - bubble_cnt=1.
- Double stall (two stall cycles) → two NOPs in E, D unchanged throughout, bubble_cnt=2.
- Saturation: with CNT_W=4, hold stall for 20 cycles → bubble_cnt stops at 4'hF.
- Wrap and reset during stall:
  - pc_F=32'hFFFF_FFFC → pc8_D=32'h0000_0004;
  - assert rst_n=0 while stall=1 → all stages NOP, bubble_cnt=0.

Source files
------------

// File: rtl/pipe_stage_regs_pkg.sv
// Constants and stage indices shared by the pipeline registers and the
// forward/stall units of the 5-stage MIPS core.
package pipe_stage_regs_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam logic [31:0] PC8_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        STG_D = 2'd0,
        STG_E = 2'd1,
        STG_M = 2'd2,
        STG_W = 2'd3
    } stage_e;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear to the
// reset value (wins over load), and a load enable.
module pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D, D/E, E/M and M/W pipeline registers. A stall freezes F/D and turns the
// D/E load into a bubble, which is also counted in a saturating counter.
module pipe_stage_regs #(
    parameter logic [31:0] NOP_WORD = pipe_stage_regs_pkg::NOP_WORD,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [31:0]      instr_F,
    input  logic [31:0]      pc_F,
    input  logic [31:0]      alu_out_E,
    input  logic [31:0]      rt_data_E,
    input  logic [31:0]      dm_rdata_M,
    output logic [31:0]      instrD,
    output logic [31:0]      instrE,
    output logic [31:0]      instrM,
    output logic [31:0]      instrW,
    output logic [31:0]      pc8_D,
    output logic [31:0]      pc8_E,
    output logic [31:0]      pc8_M,
    output logic [31:0]      pc8_W,
    output logic [31:0]      alu_M,
    output logic [31:0]      st_data_M,
    output logic [31:0]      alu_W,
    output logic [31:0]      mem_W,
    output logic [CNT_W-1:0] bubble_cnt
);

    import pipe_stage_regs_pkg::*;

    logic [31:0] pc8_next;

    assign pc8_next = pc_F + PC8_OFFSET;

    pipe_reg #(.WIDTH(64), .RST_VAL({NOP_WORD, 32'h0})) u_fd (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .clr   (1'b0),
        .d     ({instr_F, pc8_next}),
        .q     ({instrD, pc8_D})
    );

    // A bubble is just the reset value loaded synchronously: NOP with pc8 = 0.
    pipe_reg #(.WIDTH(64), .RST_VAL({NOP_WORD, 32'h0})) u_de (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (stall),
        .d     ({instrD, pc8_D}),
        .q     ({instrE, pc8_E})
    );

    pipe_reg #(.WIDTH(128), .RST_VAL({NOP_WORD, 96'h0})) u_em (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .d     ({instrE, pc8_E, alu_out_E, rt_data_E}),
        .q     ({instrM, pc8_M, alu_M, st_data_M})
    );

    pipe_reg #(.WIDTH(128), .RST_VAL({NOP_WORD, 96'h0})) u_mw (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .d     ({instrM, pc8_M, alu_M, dm_rdata_M}),
        .q     ({instrW, pc8_W, alu_W, mem_W})
    );

    // Counter sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (stall && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Self-checking bench for pipe_stage_regs: slot-queue reference model compared
// every cycle, plus hand-computed checkpoints.
module tb_pipe_stage_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] instr_F, pc_F, alu_out_E, rt_data_E, dm_rdata_M;
    logic [31:0] instrD, instrE, instrM, instrW;
    logic [31:0] pc8_D, pc8_E, pc8_M, pc8_W;
    logic [31:0] alu_M, st_data_M, alu_W, mem_W;
    logic [31:0] bubble_cnt;
    logic [31:0] s_instrD, s_instrE, s_instrM, s_instrW;
    logic [31:0] s_pc8_D, s_pc8_E, s_pc8_M, s_pc8_W;
    logic [31:0] s_alu_M, s_st_data_M, s_alu_W, s_mem_W;
    logic [3:0]  s_bubble_cnt;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_regs dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .instr_F(instr_F), .pc_F(pc_F),
        .alu_out_E(alu_out_E), .rt_data_E(rt_data_E), .dm_rdata_M(dm_rdata_M),
        .instrD(instrD), .instrE(instrE), .instrM(instrM), .instrW(instrW),
        .pc8_D(pc8_D), .pc8_E(pc8_E), .pc8_M(pc8_M), .pc8_W(pc8_W),
        .alu_M(alu_M), .st_data_M(st_data_M), .alu_W(alu_W), .mem_W(mem_W),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_regs #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .instr_F(instr_F), .pc_F(pc_F),
        .alu_out_E(alu_out_E), .rt_data_E(rt_data_E), .dm_rdata_M(dm_rdata_M),
        .instrD(s_instrD), .instrE(s_instrE), .instrM(s_instrM), .instrW(s_instrW),
        .pc8_D(s_pc8_D), .pc8_E(s_pc8_E), .pc8_M(s_pc8_M), .pc8_W(s_pc8_W),
        .alu_M(s_alu_M), .st_data_M(s_st_data_M), .alu_W(s_alu_W), .mem_W(s_mem_W),
        .bubble_cnt(s_bubble_cnt)
    );

    // Reference model: four instruction slots; a stall parks D and drops a NOP into E.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc8;
    } slot_t;

    slot_t       slots [4];
    logic [31:0] m_alu_M, m_st_M, m_alu_W, m_mem_W;
    int          m_bubbles;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slots[i] = '{32'h0, 32'h0};
            m_alu_M = 0; m_st_M = 0; m_alu_W = 0; m_mem_W = 0;
            m_bubbles = 0;
        end else begin
            slots[3] = slots[2];
            slots[2] = slots[1];
            if (stall) begin
                slots[1] = '{32'h0, 32'h0};
                m_bubbles = m_bubbles + 1;
            end else begin
                slots[1] = slots[0];
                slots[0] = '{instr_F, pc_F + 32'd8};
            end
            m_alu_W = m_alu_M;
            m_mem_W = dm_rdata_M;
            m_alu_M = alu_out_E;
            m_st_M  = rt_data_E;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput("instrD", instrD, slots[0].instr);
            checkOutput("instrE", instrE, slots[1].instr);
            checkOutput("instrM", instrM, slots[2].instr);
            checkOutput("instrW", instrW, slots[3].instr);
            checkOutput("pc8_D", pc8_D, slots[0].pc8);
            checkOutput("pc8_E", pc8_E, slots[1].pc8);
            checkOutput("pc8_M", pc8_M, slots[2].pc8);
            checkOutput("pc8_W", pc8_W, slots[3].pc8);
            checkOutput("alu_M", alu_M, m_alu_M);
            checkOutput("st_data_M", st_data_M, m_st_M);
            checkOutput("alu_W", alu_W, m_alu_W);
            checkOutput("mem_W", mem_W, m_mem_W);
            checkOutput("bubble_cnt", bubble_cnt, 32'(m_bubbles));
            checkOutput("bubble_cnt_sat", {28'h0, s_bubble_cnt}, (m_bubbles > 15) ? 32'd15 : 32'(m_bubbles));
        end
    end

    task automatic applyStimulus(input logic s, input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] r, input logic [31:0] m);
        @(negedge clk);
        #1;
        stall = s; instr_F = i; pc_F = p; alu_out_E = a; rt_data_E = r; dm_rdata_M = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1; stall = 1'b0;
        instr_F = 0; pc_F = 0; alu_out_E = 0; rt_data_E = 0; dm_rdata_M = 0;
        #1 rst_n = 1'b0;
        started = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Build up non-zero state, then reset asynchronously mid-cycle.
        repeat (3) applyStimulus(1'b0, 32'h1234_5678, 32'h0000_0100, 32'h5, 32'h6, 32'h7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_instrD", instrD, 32'h0);
        checkOutput("async_rst_instrW", instrW, 32'h0);
        checkOutput("async_rst_pc8_D", pc8_D, 32'h0);
        checkOutput("async_rst_alu_M", alu_M, 32'h0);
        checkOutput("async_rst_mem_W", mem_W, 32'h0);

        // Release: first edge loads addi.
        @(negedge clk);
        #1;
        rst_n = 1'b1; stall = 1'b0; instr_F = 32'h2008_0005; pc_F = 32'h3000;
        alu_out_E = 32'h11; rt_data_E = 32'hA1; dm_rdata_M = 32'hD1;
        @(posedge clk);
        #1;
        checkOutput("release_instrD", instrD, 32'h2008_0005);
        checkOutput("release_pc8_D", pc8_D, 32'h3008);

        // Straight flow: ori, add, sw.
        applyStimulus(1'b0, 32'h3409_0007, 32'h3004, 32'h22, 32'hA2, 32'hD2);
        checkOutput("flow_alu_W_e2", alu_W, 32'h11);
        applyStimulus(1'b0, 32'h0109_5020, 32'h3008, 32'h33, 32'hA3, 32'hD3);
        applyStimulus(1'b0, 32'hAC0A_0000, 32'h300C, 32'h44, 32'hA4, 32'hD4);
        checkOutput("flow_instrW", instrW, 32'h2008_0005);
        checkOutput("flow_pc8_W", pc8_W, 32'h3008);
        checkOutput("flow_pc8_M", pc8_M, 32'h300C);
        checkOutput("flow_pc8_E", pc8_E, 32'h3010);
        checkOutput("flow_pc8_D", pc8_D, 32'h3014);
        checkOutput("flow_alu_W", alu_W, 32'h33);
        checkOutput("flow_st_M", st_data_M, 32'hA4);
        checkOutput("flow_mem_W", mem_W, 32'hD4);

        // Single stall: lw $1 then beq $1,$2.
        applyStimulus(1'b0, 32'h8C01_0000, 32'h3010, 32'h55, 32'hA5, 32'hD5);
        applyStimulus(1'b0, 32'h1022_0003, 32'h3014, 32'h66, 32'hA6, 32'hD6);
        applyStimulus(1'b1, 32'h2403_0001, 32'h3018, 32'h77, 32'hA7, 32'hD7);
        checkOutput("stall1_instrD", instrD, 32'h1022_0003);
        checkOutput("stall1_instrE", instrE, 32'h0);
        checkOutput("stall1_pc8_E", pc8_E, 32'h0);
        checkOutput("stall1_instrM", instrM, 32'h8C01_0000);
        checkOutput("stall1_bubbles", bubble_cnt, 32'd1);
        applyStimulus(1'b0, 32'h2403_0001, 32'h3018, 32'h88, 32'hA8, 32'hD8);
        checkOutput("stall1_lw_W", instrW, 32'h8C01_0000);
        checkOutput("stall1_beq_E", instrE, 32'h1022_0003);
        checkOutput("stall1_beq_pc8_E", pc8_E, 32'h301C);

        // Double stall: D keeps addiu, two NOPs into E, cumulative count 3.
        applyStimulus(1'b1, 32'h0000_0020, 32'h301C, 32'h99, 32'hA9, 32'hD9);
        checkOutput("stall2a_instrD", instrD, 32'h2403_0001);
        checkOutput("stall2a_instrE", instrE, 32'h0);
        applyStimulus(1'b1, 32'h0000_0020, 32'h301C, 32'h9A, 32'hAA, 32'hDA);
        checkOutput("stall2b_instrD", instrD, 32'h2403_0001);
        checkOutput("stall2b_instrE", instrE, 32'h0);
        checkOutput("stall2b_instrM", instrM, 32'h0);
        checkOutput("stall2b_bubbles", bubble_cnt, 32'd3);
        applyStimulus(1'b0, 32'h0000_0020, 32'h301C, 32'h9B, 32'hAB, 32'hDB);
        checkOutput("stall2_release_E", instrE, 32'h2403_0001);

        // Saturation: 20 more stalls -> 23 on the wide counter, 4'hF on the narrow one.
        for (int k = 0; k < 20; k++)
            applyStimulus(1'b1, 32'hFACE_0000 + 32'(k), 32'h4000, 32'(k), 32'(k + 1), 32'(k + 2));
        checkOutput("sat_wide", bubble_cnt, 32'd23);
        checkOutput("sat_narrow", {28'h0, s_bubble_cnt}, 32'hF);
        checkOutput("sat_instrD_held", instrD, 32'h0000_0020);

        // PC wrap, then reset while stalled.
        applyStimulus(1'b0, 32'h2404_0002, 32'hFFFF_FFFC, 32'h1, 32'h2, 32'h3);
        checkOutput("wrap_pc8_D", pc8_D, 32'h0000_0004);
        checkOutput("wrap_instrD", instrD, 32'h2404_0002);
        applyStimulus(1'b1, 32'h2405_0003, 32'h0000_0000, 32'h4, 32'h5, 32'h6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_stall_instrD", instrD, 32'h0);
        checkOutput("rst_stall_instrM", instrM, 32'h0);
        checkOutput("rst_stall_bubbles", bubble_cnt, 32'd0);
        checkOutput("rst_stall_sat", {28'h0, s_bubble_cnt}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1; stall = 1'b0;
        applyStimulus(1'b0, 32'h2406_0004, 32'h5000, 32'h7, 32'h8, 32'h9);
        applyStimulus(1'b0, 32'h2407_0005, 32'h5004, 32'hA, 32'hB, 32'hC);
        checkOutput("post_rst_bubbles", bubble_cnt, 32'd0);
        checkOutput("post_rst_instrE", instrE, 32'h2406_0004);
        checkOutput("post_rst_pc8_D", pc8_D, 32'h500C);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
